// File: rtl/pc_stack_register_if.sv
// pc_stack_register_if
//   Command and status bundle for the program-counter / return-stack register.
//   master : drives RegWrite, Op, Input, ResetTo; observes the status outputs.
//   slave  : the register itself; consumes the commands, drives Output,
//            Depth, Empty, Full and Error.
//   Signals:
//     RegWrite  command enable (0 = hold regardless of Op)
//     Op[2:0]   0 HOLD, 1 LOAD, 2 INC, 3 DEC, 4 CALL, 5 RET, 6-7 HOLD
//     Input     load value / call target
//     ResetTo   value taken by Output while reset is asserted
//     Output    current register value
//     Depth     number of valid return-stack entries
//     Empty     Depth == 0
//     Full      Depth == DEPTH
//     Error     sticky overflow/underflow flag
interface pc_stack_register_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             RegWrite;
  logic [2:0]       Op;
  logic [WIDTH-1:0] Input;
  logic [WIDTH-1:0] ResetTo;
  logic [WIDTH-1:0] Output;
  logic [DW-1:0]    Depth;
  logic             Empty;
  logic             Full;
  logic             Error;

  modport master (
    output RegWrite, Op, Input, ResetTo,
    input  Output, Depth, Empty, Full, Error
  );

  modport slave (
    input  RegWrite, Op, Input, ResetTo,
    output Output, Depth, Empty, Full, Error
  );
endinterface

// File: rtl/pc_stack_register.sv
// pc_stack_register
//   Program counter for the accumulator processor. Holds a WIDTH-bit value
//   that can be held, loaded, stepped up/down by STEP, or redirected by
//   CALL/RET through a DEPTH-entry LIFO return-address stack. Calling with
//   a full stack or returning with an empty one leaves the state untouched
//   and sets a sticky Error flag that only reset clears.
//   Ports:
//     CLK    rising-edge clock
//     Reset  synchronous, active-low reset (loads bus.ResetTo, empties stack)
//     bus    pc_stack_register_if.slave command/status bundle
module pc_stack_register #(
  parameter int WIDTH = 16,
  parameter int STEP  = 2,
  parameter int DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 Reset,
  pc_stack_register_if.slave   bus
);

  localparam int              DW      = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [DW-1:0]    DEPTH_W = DW'(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] out_q, out_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic             empty, full, push;
  logic [WIDTH-1:0] top, ret_addr;

  assign op = op_e'(bus.Op);

  always_comb begin
    empty    = (depth_q == '0);
    full     = (depth_q == DEPTH_W);
    ret_addr = out_q + STEP_W;

    // Top of stack is entry depth_q-1; searched rather than indexed so the
    // index never leaves the array range when the stack is empty.
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) top = stack_q[i];
    end

    out_d   = out_q;
    depth_d = depth_q;
    error_d = error_q;
    push    = 1'b0;

    if (bus.RegWrite) begin
      case (op)
        OP_LOAD: out_d = bus.Input;
        OP_INC:  out_d = out_q + STEP_W;
        OP_DEC:  out_d = out_q - STEP_W;
        OP_CALL: begin
          if (full) begin
            error_d = 1'b1;
          end else begin
            push    = 1'b1;
            out_d   = bus.Input;
            depth_d = depth_q + DW'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            error_d = 1'b1;
          end else begin
            out_d   = top;
            depth_d = depth_q - DW'(1);
          end
        end
        default: ;
      endcase
    end

    // Push writes the slot just above the current top; suppressed under reset.
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = (push && Reset && depth_q == DW'(i)) ? ret_addr : stack_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      out_q   <= bus.ResetTo;
      depth_q <= '0;
      error_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      depth_q <= depth_d;
      error_q <= error_d;
    end
  end

  // Stack storage is never cleared; entries above depth_q are unobservable.
  always_ff @(posedge CLK) begin
    stack_q <= stack_d;
  end

  assign bus.Output = out_q;
  assign bus.Depth  = depth_q;
  assign bus.Empty  = empty;
  assign bus.Full   = full;
  assign bus.Error  = error_q;

endmodule

// File: tb/tb_pc_stack_register.sv
// tb_pc_stack_register
//   Directed walk through the register's behaviour followed by randomized
//   commands, each compared against a queue-based reference model.
module tb_pc_stack_register;

  localparam int WIDTH = 16;
  localparam int STEP  = 2;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic Reset;

  always #5 CLK = ~CLK;

  pc_stack_register_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_stack_register #(.WIDTH(WIDTH), .STEP(STEP), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  // Reference model
  logic [15:0] m_out;
  logic [15:0] m_stk [$];
  bit          m_err;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},   32'(bus.Output), 32'(m_out));
    check({tag, ".depth"}, 32'(bus.Depth),  32'(m_stk.size()));
    check({tag, ".empty"}, 32'(bus.Empty),  32'(m_stk.size() == 0));
    check({tag, ".full"},  32'(bus.Full),   32'(m_stk.size() == DEPTH));
    check({tag, ".err"},   32'(bus.Error),  32'(m_err));
  endtask

  task automatic step(input string tag, input bit rst_n, input bit rw, input int op,
                      input logic [15:0] din, input logic [15:0] rto);
    @(negedge CLK);
    Reset        = rst_n;
    bus.RegWrite = rw;
    bus.Op       = 3'(op);
    bus.Input    = din;
    bus.ResetTo  = rto;
    @(posedge CLK);
    if (!rst_n) begin
      m_out = rto;
      m_stk.delete();
      m_err = 1'b0;
    end else if (rw) begin
      case (op)
        1: m_out = din;
        2: m_out = 16'(m_out + STEP);
        3: m_out = 16'(m_out - STEP);
        4: if (m_stk.size() == DEPTH) m_err = 1'b1;
           else begin
             m_stk.push_back(16'(m_out + STEP));
             m_out = din;
           end
        5: if (m_stk.size() == 0) m_err = 1'b1;
           else m_out = m_stk.pop_back();
        default: ;
      endcase
    end
    #1;
    check_all(tag);
  endtask

  localparam logic [15:0] RV = 16'h0040;

  initial begin
    Reset        = 1'b1;
    bus.RegWrite = 1'b0;
    bus.Op       = 3'd0;
    bus.Input    = '0;
    bus.ResetTo  = '0;
    m_out        = '0;
    m_err        = 1'b0;

    // Reset and load
    step("reset",  0, 0, 0, 16'h0000, RV);
    step("load",   1, 1, 1, 16'h1234, RV);

    // Count and wrap
    step("ldfffe", 1, 1, 1, 16'hFFFE, RV);
    step("incwrap",1, 1, 2, 16'h0000, RV);
    step("decwrap",1, 1, 3, 16'h0000, RV);

    // Call/return nesting
    step("ld10",   1, 1, 1, 16'h0010, RV);
    step("call1",  1, 1, 4, 16'h0100, RV);
    step("call2",  1, 1, 4, 16'h0200, RV);
    step("ret2",   1, 1, 5, 16'h0000, RV);
    step("ret1",   1, 1, 5, 16'h0000, RV);

    // Overflow
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 1, 4, 16'(16'h1000 + i * 16'h10), RV);
    step("ovf",    1, 1, 4, 16'h0300, RV);
    step("ret_ok", 1, 1, 5, 16'h0000, RV);

    // Underflow and stickiness
    step("rst2",   0, 1, 4, 16'h7777, RV);
    step("unf",    1, 1, 5, 16'h0000, RV);
    step("sticky", 1, 1, 2, 16'h0000, RV);
    step("sticky2",1, 1, 1, 16'h4444, RV);

    // Enable and illegal ops
    step("rw0",    1, 0, 1, 16'hBEEF, RV);
    step("op6",    1, 1, 6, 16'hBEEF, RV);
    step("op7",    1, 1, 7, 16'hBEEF, RV);

    // Output must not follow Input/Op between edges
    bus.Input = 16'hA5A5;
    bus.Op    = 3'd1;
    bus.RegWrite = 1'b1;
    #2;
    check("comb_iso", 32'(bus.Output), 32'(m_out));

    // Reset mid-operation with a CALL in flight
    step("rst3",   0, 0, 0, 16'h0000, RV);
    step("unf2",   1, 1, 5, 16'h0000, RV);
    for (int i = 0; i < 3; i++) step("push3", 1, 1, 4, 16'(16'h2000 + i), RV);
    step("rstcall",0, 1, 4, 16'h0900, 16'h0080);
    step("call_a", 1, 1, 4, 16'h0500, RV);
    step("ret_a",  1, 1, 5, 16'h0000, RV);
    step("unf3",   1, 1, 5, 16'h0000, RV);

    // Randomized commands
    for (int n = 0; n < 500; n++) begin
      step("rand",
           $urandom_range(0, 39) != 0,
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)),
           16'($urandom),
           16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard bound in case the clock or DUT wedges the sequence.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
